// File: rtl/byte_stream_packer_pkg.sv
// Shared constants for the byte packer and the downstream processor it feeds.
// Lane count is shared so packed word widths always agree on both sides.
package byte_stream_packer_pkg;

    localparam int unsigned BYTE_WIDTH                 = 8;
    localparam int unsigned DEFAULT_REPLICATION_FACTOR = 3;
    localparam logic [BYTE_WIDTH-1:0] DEFAULT_PAD_BYTE = 8'h00;

    // Lane index width; a single-lane packer still needs one bit.
    function automatic int unsigned lane_idx_width(input int unsigned lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/packer_output_stage.sv
// One-entry valid/ready register slice holding a packed word with its keep mask and last flag.
// out_free_c tells the producer a load will be absorbed this cycle.
module packer_output_stage
    import byte_stream_packer_pkg::*;
#(
    parameter int unsigned LANES = DEFAULT_REPLICATION_FACTOR
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        load,
    input  logic [BYTE_WIDTH*LANES-1:0] load_data,
    input  logic [LANES-1:0]            load_keep,
    input  logic                        load_last,
    input  logic                        out_ready,
    output logic [BYTE_WIDTH*LANES-1:0] out_data,
    output logic [LANES-1:0]            out_keep,
    output logic                        out_last,
    output logic                        out_valid,
    output logic                        out_free_c
);

    assign out_free_c = !out_valid || out_ready;

    // A load in the same cycle as a handshake keeps the slice full with the new word.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else if (enable) begin
            if (load) begin
                out_data  <= load_data;
                out_keep  <= load_keep;
                out_last  <= load_last;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/byte_stream_packer.sv
// Packs a byte stream into REPLICATION_FACTOR-lane words, padding short final words
// and flagging real lanes so packet boundaries survive packing.
module byte_stream_packer
    import byte_stream_packer_pkg::*;
#(
    parameter int unsigned            REPLICATION_FACTOR = DEFAULT_REPLICATION_FACTOR,
    parameter logic [BYTE_WIDTH-1:0]  PAD_BYTE           = DEFAULT_PAD_BYTE
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic                                     enable,
    input  logic [BYTE_WIDTH-1:0]                    in_data,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic                                     in_last,
    output logic [BYTE_WIDTH*REPLICATION_FACTOR-1:0] out_data,
    output logic [REPLICATION_FACTOR-1:0]            out_keep,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic                                     out_last
);

    localparam int unsigned R         = REPLICATION_FACTOR;
    localparam int unsigned WORD_W    = BYTE_WIDTH * R;
    localparam int unsigned IDX_W     = lane_idx_width(R);
    localparam int unsigned LAST_LANE = R - 1;
    localparam logic [WORD_W-1:0] PAD_WORD = {R{PAD_BYTE}};

    logic [WORD_W-1:0] acc_data, acc_data_nxt;
    logic [R-1:0]      acc_keep, acc_keep_nxt;
    logic              acc_last, acc_last_nxt;
    logic              acc_full, acc_full_nxt;
    logic [IDX_W-1:0]  lane_idx, lane_idx_nxt;

    logic out_free;
    logic accept;
    logic transfer;

    // out_ready reaches in_ready combinationally so a full accumulator never costs a bubble.
    assign in_ready = enable && (!acc_full || out_free);
    assign accept   = in_valid && in_ready;
    assign transfer = enable && acc_full && out_free;

    // A transfer empties the accumulator first, so a same-cycle byte lands in lane 0.
    always_comb begin
        acc_data_nxt = acc_data;
        acc_keep_nxt = acc_keep;
        acc_last_nxt = acc_last;
        acc_full_nxt = acc_full;
        lane_idx_nxt = lane_idx;

        if (transfer) begin
            acc_data_nxt = PAD_WORD;
            acc_keep_nxt = '0;
            acc_full_nxt = 1'b0;
        end

        if (accept) begin
            for (int unsigned k = 0; k < R; k++) begin
                if (lane_idx == IDX_W'(k)) begin
                    acc_data_nxt[k*BYTE_WIDTH +: BYTE_WIDTH] = in_data;
                    acc_keep_nxt[k]                          = 1'b1;
                end
            end
            if (in_last || lane_idx == IDX_W'(LAST_LANE)) begin
                acc_full_nxt = 1'b1;
                acc_last_nxt = in_last;
                lane_idx_nxt = '0;
            end else begin
                lane_idx_nxt = lane_idx + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_data <= PAD_WORD;
            acc_keep <= '0;
            acc_last <= 1'b0;
            acc_full <= 1'b0;
            lane_idx <= '0;
        end else begin
            acc_data <= acc_data_nxt;
            acc_keep <= acc_keep_nxt;
            acc_last <= acc_last_nxt;
            acc_full <= acc_full_nxt;
            lane_idx <= lane_idx_nxt;
        end
    end

    packer_output_stage #(
        .LANES (R)
    ) u_output_stage (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .load       (transfer),
        .load_data  (acc_data),
        .load_keep  (acc_keep),
        .load_last  (acc_last),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_keep   (out_keep),
        .out_last   (out_last),
        .out_valid  (out_valid),
        .out_free_c (out_free)
    );

endmodule
